// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the 4x4 output-stationary systolic array: buffers A and B,
// then streams diagonally skewed, zero-padded west/north beats after a clear pulse.
module systolic_skew_feeder #(
  parameter int DW        = 32,
  parameter int N         = 4,
  parameter int DRAIN_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_mat,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          array_clr,
  output logic          feed_valid,
  output logic [DW-1:0] west0,
  output logic [DW-1:0] west1,
  output logic [DW-1:0] west2,
  output logic [DW-1:0] west3,
  output logic [DW-1:0] north0,
  output logic [DW-1:0] north1,
  output logic [DW-1:0] north2,
  output logic [DW-1:0] north3,
  output logic          done
);
  localparam int WORDS = N * N;
  localparam int AW    = $clog2(WORDS);
  localparam int BEATS = 3 * N - 2;
  localparam int MW    = $clog2(BEATS);
  localparam int DCW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [MW-1:0]  LAST_BEAT  = MW'(BEATS - 1);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [MW-1:0]  m_q, m_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           done_q, done_d;
  logic           busy_q, clr_q, fv_q;

  logic [DW-1:0]  a_q [WORDS];
  logic [DW-1:0]  b_q [WORDS];
  logic [DW-1:0]  west_d [N];
  logic [DW-1:0]  north_d [N];
  logic [DW-1:0]  west_q [N];
  logic [DW-1:0]  north_q [N];

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    case (state_q)
      // A start coinciding with the done pulse is dropped, not queued.
      IDLE: if (start && !done_q) state_d = CLR;
      CLR: begin
        state_d = RUN;
        m_d     = '0;
      end
      RUN: begin
        if (m_q == LAST_BEAT) begin
          if (DRAIN_CYC == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end else begin
          m_d = m_q + MW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == LAST_DRAIN) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Feed words are looked up from the next beat index so they land in the
  // same registered cycle that feed_valid marks.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_feed
      int            k;
      logic [AW-1:0] w_idx, n_idx;
      logic [DW-1:0] w_v, n_v;
      always_comb begin
        k     = int'(m_d) - gi;
        w_idx = AW'(gi * N + k);
        n_idx = AW'(k * N + gi);
        w_v   = '0;
        n_v   = '0;
        if (state_d == RUN && k >= 0 && k < N) begin
          w_v = a_q[w_idx];
          n_v = b_q[n_idx];
        end
      end
      assign west_d[gi]  = w_v;
      assign north_d[gi] = n_v;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      fv_q    <= 1'b0;
      for (int w = 0; w < WORDS; w++) begin
        a_q[w] <= '0;
        b_q[w] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= '0;
        north_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      clr_q   <= (state_d == CLR);
      fv_q    <= (state_d == RUN);
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= west_d[i];
        north_q[i] <= north_d[i];
      end
      if (wr_en && state_q == IDLE) begin
        if (wr_mat) b_q[wr_addr] <= wr_data;
        else        a_q[wr_addr] <= wr_data;
      end
    end
  end

  assign busy       = busy_q;
  assign array_clr  = clr_q;
  assign feed_valid = fv_q;
  assign done       = done_q;
  assign west0      = west_q[0];
  assign west1      = west_q[1];
  assign west2      = west_q[2];
  assign west3      = west_q[3];
  assign north0     = north_q[0];
  assign north1     = north_q[1];
  assign north2     = north_q[2];
  assign north3     = north_q[3];
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: cycle model keyed on cycles-since-start,
// hand vectors for the reference pattern, and an array-product check per run.
module tb_systolic_skew_feeder;
  localparam int DW     = 32;
  localparam int N      = 4;
  localparam int DRAIN  = 2;
  localparam int R      = 3 * N - 2;
  localparam int DONE_C = 1 + R + DRAIN + 1;

  logic clk = 1'b0;
  logic rst, wr_en, wr_mat, start;
  logic [3:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic busy, array_clr, feed_valid, done;
  logic [DW-1:0] west0, west1, west2, west3, north0, north1, north2, north3;
  logic [DW-1:0] w_o [N];
  logic [DW-1:0] n_o [N];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DW(DW), .N(N), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mat(wr_mat), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .array_clr(array_clr),
    .feed_valid(feed_valid), .west0(west0), .west1(west1), .west2(west2),
    .west3(west3), .north0(north0), .north1(north1), .north2(north2),
    .north3(north3), .done(done)
  );

  assign w_o[0] = west0;  assign w_o[1] = west1;
  assign w_o[2] = west2;  assign w_o[3] = west3;
  assign n_o[0] = north0; assign n_o[1] = north1;
  assign n_o[2] = north2; assign n_o[3] = north3;

  int n_cmp = 0;
  int n_bad = 0;
  int runs  = 0;

  // Model: matrices, and ph = cycles since the accepted start (-1 when idle).
  logic [DW-1:0] ma [N*N];
  logic [DW-1:0] mb [N*N];
  int ph = -1;
  bit clean = 0;
  logic [DW-1:0] wh [R][N];
  logic [DW-1:0] nh [R][N];

  typedef struct {
    int ph;
    logic clr;
    logic fv;
    logic bz;
    logic dn;
    logic [N-1:0][DW-1:0] w;
    logic [N-1:0][DW-1:0] n;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h expected %0h (t=%0t ph=%0d)", name, act, exp, $time, ph);
    end
  endtask

  function automatic logic [DW-1:0] exp_w(int i);
    int k;
    k = ph - 2 - i;
    if (ph >= 2 && ph < 2 + R && k >= 0 && k < N) return ma[i*N+k];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_n(int j);
    int k;
    k = ph - 2 - j;
    if (ph >= 2 && ph < 2 + R && k >= 0 && k < N) return mb[k*N+j];
    return '0;
  endfunction

  // Multiply the captured stream through an ideal output-stationary array.
  task automatic check_array;
    logic [DW-1:0] acc, prod;
    int a, b;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc  = '0;
        prod = '0;
        for (int t = 0; t < R + 2 * N; t++) begin
          a = t - j;
          b = t - i;
          if (a >= 0 && a < R && b >= 0 && b < R) acc += wh[a][i] * nh[b][j];
        end
        for (int k = 0; k < N; k++) prod += ma[i*N+k] * mb[k*N+j];
        chk($sformatf("C[%0d][%0d]", i, j), acc, prod);
      end
    end
  endtask

  task automatic check_all;
    chk("busy", busy, (ph >= 1 && ph < DONE_C));
    chk("array_clr", array_clr, (ph == 1));
    chk("feed_valid", feed_valid, (ph >= 2 && ph < 2 + R));
    chk("done", done, (ph == DONE_C));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("west%0d", i), w_o[i], exp_w(i));
      chk($sformatf("north%0d", i), n_o[i], exp_n(i));
    end
    if (ph == 1) clean = 1;
    if (ph >= 2 && ph < 2 + R) begin
      for (int i = 0; i < N; i++) begin
        wh[ph-2][i] = w_o[i];
        nh[ph-2][i] = n_o[i];
      end
    end
    if (ph == DONE_C && clean) check_array;
  endtask

  task automatic step(input bit s, input bit we, input bit wm,
                      input logic [3:0] wa, input logic [DW-1:0] wd);
    bit idle_now;
    start = s; wr_en = we; wr_mat = wm; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    idle_now = (ph < 0) || (ph == DONE_C);
    if (we && idle_now) begin
      if (wm) mb[wa] = wd;
      else    ma[wa] = wd;
    end
    if (ph < 0) begin
      if (s) ph = 1;
    end else if (ph == DONE_C) begin
      ph = -1;
      clean = 0;
    end else begin
      ph++;
    end
    @(negedge clk);
    check_all;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(0, 0, 0, 4'd0, '0);
  endtask

  task automatic tbl_check;
    for (int e = 0; e < 8; e++) begin
      if (tbl[e].ph == ph) begin
        chk($sformatf("tbl%0d.clr", e), array_clr, tbl[e].clr);
        chk($sformatf("tbl%0d.fv", e), feed_valid, tbl[e].fv);
        chk($sformatf("tbl%0d.busy", e), busy, tbl[e].bz);
        chk($sformatf("tbl%0d.done", e), done, tbl[e].dn);
        for (int i = 0; i < N; i++) begin
          chk($sformatf("tbl%0d.west%0d", e, i), w_o[i], tbl[e].w[i]);
          chk($sformatf("tbl%0d.north%0d", e, i), n_o[i], tbl[e].n[i]);
        end
      end
    end
  endtask

  // Start (with optional coincident write), then run to the done cycle.
  task automatic run_seq(input bit noise, input bit use_tbl, input bit we0, input bit wm0,
                         input logic [3:0] wa0, input logic [DW-1:0] wd0);
    int guard;
    step(1, we0, wm0, wa0, wd0);
    if (use_tbl) tbl_check;
    guard = 0;
    while (ph != DONE_C && ph > 0 && guard < 40) begin
      if (noise) step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      4'($urandom_range(0, 15)), $urandom);
      else step(0, 0, 0, 4'd0, '0);
      if (use_tbl) tbl_check;
      guard++;
    end
    chk("reached_done", (ph == DONE_C), 1);
    runs++;
    $display("run %0d finished at t=%0t", runs, $time);
  endtask

  task automatic mid_reset;
    #2 rst = 1'b1;
    ph = -1;
    clean = 0;
    for (int w = 0; w < N * N; w++) begin
      ma[w] = '0;
      mb[w] = '0;
    end
    #1 check_all;
    @(negedge clk);
    check_all;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, '0, '0};
    tbl[1] = '{2,  1'b0, 1'b1, 1'b1, 1'b0, {32'd0, 32'd0, 32'd0, 32'd1}, {32'd0, 32'd0, 32'd0, 32'd16}};
    tbl[2] = '{3,  1'b0, 1'b1, 1'b1, 1'b0, {32'd0, 32'd0, 32'd5, 32'd2}, {32'd0, 32'd0, 32'd17, 32'd20}};
    tbl[3] = '{5,  1'b0, 1'b1, 1'b1, 1'b0, {32'd13, 32'd10, 32'd7, 32'd4}, {32'd19, 32'd22, 32'd25, 32'd28}};
    tbl[4] = '{8,  1'b0, 1'b1, 1'b1, 1'b0, {32'd16, 32'd0, 32'd0, 32'd0}, {32'd31, 32'd0, 32'd0, 32'd0}};
    tbl[5] = '{11, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0};
    tbl[6] = '{12, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0};
    tbl[7] = '{14, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0};

    for (int w = 0; w < N * N; w++) begin
      ma[w] = '0;
      mb[w] = '0;
    end
    rst = 1'b1; start = 0; wr_en = 0; wr_mat = 0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_all;
    rst = 1'b0;
    idle(2);

    // Reference pattern with hand vectors.
    for (int w = 0; w < N * N; w++) step(0, 1, 0, 4'(w), DW'(w + 1));
    for (int w = 0; w < N * N; w++) step(0, 1, 1, 4'(w), DW'(16 + w));
    run_seq(0, 1, 0, 0, 4'd0, '0);
    idle(2);

    // Start and write at beat 4 are ignored; a replay shows A[0][0] intact.
    step(1, 0, 0, 4'd0, '0);
    while (ph != DONE_C && ph > 0) step(ph == 6, ph == 6, 0, 4'd0, 32'hDEAD);
    idle(1);
    run_seq(0, 0, 0, 0, 4'd0, '0);
    chk("a00_replay", wh[0][0], 32'd1);
    idle(1);

    // Identity times ramp: array result equals B.
    for (int w = 0; w < N * N; w++) step(0, 1, 0, 4'(w), (w / N == w % N) ? 32'd1 : 32'd0);
    for (int w = 0; w < N * N; w++) step(0, 1, 1, 4'(w), DW'(100 + 3 * w));
    run_seq(0, 0, 0, 0, 4'd0, '0);

    // Back-to-back: start in the done cycle is dropped, next cycle accepted.
    step(1, 0, 0, 4'd0, '0);
    chk("b2b_dropped", busy, 1'b0);
    run_seq(0, 0, 0, 0, 4'd0, '0);
    idle(1);

    // Reset at beat 5, then a run from cleared buffers.
    step(1, 0, 0, 4'd0, '0);
    while (ph < 7 && ph > 0) step(0, 0, 0, 4'd0, '0);
    mid_reset;
    idle(20);
    run_seq(0, 0, 0, 0, 4'd0, '0);
    idle(1);

    // Write and start in the same cycle; the write is used at beat 6.
    step(0, 1, 0, 4'd15, 32'd9);
    step(1, 1, 1, 4'd15, 32'd7);
    while (ph != 8 && ph > 0) step(0, 0, 0, 4'd0, '0);
    chk("same_cycle_north3", north3, 32'd7);
    while (ph != DONE_C && ph > 0) step(0, 0, 0, 4'd0, '0);
    idle(1);

    // Randomised matrices with noise on the inputs while busy.
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 2 * N * N; w++)
        step(0, 1, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom);
      idle($urandom_range(0, 3));
      run_seq(1, 0, $urandom_range(0, 1) == 1, 1, 4'($urandom_range(0, 15)), $urandom);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
